alu_share_arbiter: RTL
======================

# alu_share_arbiter

Sequences one shared 32-bit integer ALU between NREQ requesters, for example the execute datapath, branch comparator and address generator in the multi-cycle core variant. Each requester issues an operation with a valid/ready handshake and gets back a registered result plus branch flags on a valid/ready response channel. Arbitration is round-robin. Exactly one operation is in flight at a time. The ALU itself sits outside this block and connects through the alu_* ports.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- W, 32, operand/result width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot, high for the accepted requester in the accept cycle
- req_a  in  NREQ x W  operand A per requester
- req_b  in  NREQ x W  operand B per requester
- req_op  in  NREQ x 4  ALU operation code per requester
- rsp_valid  out  NREQ  one-hot, response pending for requester i
- rsp_ready  in  NREQ  requester i accepts its response
- rsp_result  out  W  result, shared bus, meaningful only where rsp_valid is high
- rsp_blt, rsp_bgt, rsp_zero  out  1 each  registered branch flags from the ALU
- rsp_err  out  1  operation code was illegal
- alu_src_a, alu_src_b  out  W  operands driven to the ALU
- alu_op  out  4  operation driven to the ALU
- alu_result  in  W  ALU result
- alu_blt, alu_bgt, alu_zero  in  1 each  ALU flags
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, select the winner by round-robin and assert req_ready[winner] combinationally.
  - At the clock edge, latch a, b, op and the grant index, then go to EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC:
  - Drive the latched operands and op on alu_*.
  - At the clock edge, register alu_result and the three flags into the response registers, then go to RESP.
  - If op is illegal, force the result and flags to 0 and set rsp_err. The ALU value is ignored.
- RESP:
  - rsp_valid[grant] stays high until rsp_ready[grant] is sampled high.
  - On the handshake, if any req_valid is high, perform a new arbitration in the same cycle (req_ready asserted, operands latched) and go directly to EXEC. Otherwise go to IDLE.
- Legal op codes: 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000, 1010, 1100. All other codes are illegal.
- Round-robin:
  - The pointer resets to 0.
  - The search starts at the pointer and wraps modulo NREQ.
  - After a grant to i, the pointer becomes (i+1) mod NREQ.
- Outside EXEC, alu_src_a, alu_src_b and alu_op hold their last latched values, so the ALU inputs do not toggle.
- rsp_ready to a non-granted index is ignored. req_valid may drop without being accepted, and no state is kept for it.

## Timing
- Reset values:
  - state IDLE, pointer 0
  - req_ready 0, rsp_valid 0
  - rsp_result 0, all flags 0, rsp_err 0
  - alu_src_a, alu_src_b, alu_op 0
  - busy 0
- Latency: an accept at edge 0 gives rsp_valid high after edge 1, so the response is visible one cycle after the accept edge.
- Throughput:
  - With back-to-back requests and rsp_ready held high, one operation completes every 2 cycles (accept or handshake edge, then EXEC edge).
  - From IDLE, the first operation takes the same 2 cycles.
- Simultaneous events:
  - A requester may present a new req_valid in the same cycle it handshakes its response. It competes normally under round-robin.
  - A response handshake and a new accept in RESP happen on the same edge.
- Reset asserted mid-operation clears state and outputs immediately. The in-flight operation is dropped without a response.

## Structure
- Shared package alu_pkg holds:
  - typedef alu_op_t (4-bit)
  - localparams for every op code (ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLTU, ALU_SLT, ALU_SUBU, ALU_SRL, ALU_SRA)
  - function is_legal_op
  - typedef arb_state_t enum {IDLE, EXEC, RESP}
- One sub-module, rr_arbiter: inputs request vector and pointer, outputs one-hot grant and encoded index. It is combinational and parameterized by NREQ.

## Test plan
- Single op: req 0 with a=5, b=7, op=ADD; one cycle later rsp_valid[0]=1, rsp_result=12, flags 0.
- Subtract flags: a=3, b=9, op=SUB gives result 0xFFFFFFFA, rsp_blt=1, rsp_bgt=0, rsp_zero=0. a=9, b=9 gives rsp_zero=1.
- Fairness: both requesters held valid with rsp_ready=1 for 6 operations gives grant order 0,1,0,1,0,1, one response every 2 cycles.
- Illegal op 1111: rsp_err=1, rsp_result=0. The next legal op clears rsp_err.
- Backpressure: rsp_ready[1]=0 for 5 cycles keeps rsp_valid[1] high, holds rsp_result, busy=1, and req_ready stays 0 for requester 0 throughout.
- Reset mid-EXEC: drop reset_n during EXEC; all outputs are 0 immediately, and after release the next grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, legality check and arbiter FSM states.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_XOR  = 4'b0010;
  localparam alu_op_t ALU_ADD  = 4'b0011;
  localparam alu_op_t ALU_SUB  = 4'b0100;
  localparam alu_op_t ALU_SLL  = 4'b0101;
  localparam alu_op_t ALU_SLTU = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_SUBU = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1010;
  localparam alu_op_t ALU_SRA  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(alu_op_t op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SLL,
      ALU_SLTU, ALU_SLT, ALU_SUBU, ALU_SRL, ALU_SRA: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int unsigned c;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      c = 32'(ptr) + 32'(i);
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[IW'(c)]) begin
        found           = 1'b1;
        grant[IW'(c)]   = 1'b1;
        idx             = IW'(c);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between NREQ requesters, one operation in flight,
// round-robin arbitration, registered result/flags on a per-requester response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_blt,
  output logic              rsp_bgt,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [W-1:0]      alu_src_a,
  output logic [W-1:0]      alu_src_b,
  output logic [3:0]        alu_op,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_blt,
  input  logic              alu_bgt,
  input  logic              alu_zero,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_q;
  logic [NREQ-1:0] gnt_c;
  logic [IW-1:0]   gnt_idx_c;
  logic            hs_c;
  logic            accept_c;
  logic            legal_c;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt_c),
    .idx   (gnt_idx_c)
  );

  // Accept from IDLE, or in RESP on the same edge as the response handshake.
  always_comb begin
    hs_c      = (state == RESP) && (|(rsp_valid & rsp_ready));
    accept_c  = (|req_valid) && ((state == IDLE) || hs_c);
    req_ready = accept_c ? gnt_c : '0;
    legal_c   = is_legal_op(alu_op_t'(alu_op));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_q      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_blt    <= 1'b0;
      rsp_bgt    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      alu_src_a  <= '0;
      alu_src_b  <= '0;
      alu_op     <= '0;
      busy       <= 1'b0;
    end else begin
      // Operand latches double as the ALU drive, so ALU inputs only move on accept.
      if (accept_c) begin
        alu_src_a <= req_a[32'(gnt_idx_c)*W +: W];
        alu_src_b <= req_b[32'(gnt_idx_c)*W +: W];
        alu_op    <= req_op[32'(gnt_idx_c)*4 +: 4];
        gnt_q     <= gnt_idx_c;
        ptr       <= (gnt_idx_c == IW'(NREQ - 1)) ? '0 : gnt_idx_c + IW'(1);
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_result <= legal_c ? alu_result : '0;
          rsp_blt    <= legal_c & alu_blt;
          rsp_bgt    <= legal_c & alu_bgt;
          rsp_zero   <= legal_c & alu_zero;
          rsp_err    <= ~legal_c;
          rsp_valid  <= NREQ'(1) << gnt_q;
          state      <= RESP;
        end
        RESP: begin
          if (hs_c) begin
            rsp_valid <= '0;
            state     <= accept_c ? EXEC : IDLE;
            busy      <= accept_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
